// File: rtl/decode_issue.sv
// Decode/operand-fetch stage: decodes 16-bit instructions, reads an 8x8 register file with
// writeback bypass, and interlocks RAW/WAW hazards through a per-register pending scoreboard.
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [7:0]  wb_data,
  output logic [3:0]  opcode,
  output logic [2:0]  dest_reg,
  output logic [2:0]  opAAdr,
  output logic [2:0]  opBAdr,
  output logic [3:0]  storeDataAdr,
  output logic [7:0]  operandA,
  output logic [7:0]  operandB,
  output logic        issue_valid,
  output logic [15:0] stall_count
);

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLoad  = 4'hE;
  localparam logic [3:0] OpStore = 4'hF;

  logic [3:0] f_op;
  logic [2:0] f_dest, f_src_a, f_src_b;
  logic [3:0] f_addr;

  assign f_op    = instr[15:12];
  assign f_dest  = instr[11:9];
  assign f_src_a = instr[8:6];
  assign f_src_b = instr[5:3];
  assign f_addr  = instr[3:0];

  logic is_nop, is_load, is_store, is_alu;
  logic reads_a, reads_b, writes_dest;

  assign is_nop      = (f_op == OpNop);
  assign is_load     = (f_op == OpLoad);
  assign is_store    = (f_op == OpStore);
  assign is_alu      = !is_nop && !is_load && !is_store;
  assign reads_a     = is_alu || is_store;
  assign reads_b     = is_alu;
  assign writes_dest = is_alu || is_load;

  logic [7:0] rf_q [8];
  logic [7:0] pending_q, pending_d;
  logic [7:0] wb_mask, set_mask, eff_pending;

  always_comb begin
    wb_mask = '0;
    if (wb_en) wb_mask[wb_addr] = 1'b1;
  end

  // A register being written back this cycle no longer blocks its readers.
  assign eff_pending = pending_q & ~wb_mask;

  logic hazard, accept, stall;

  assign hazard = instr_valid &&
                  ((reads_a && eff_pending[f_src_a]) ||
                   (reads_b && eff_pending[f_src_b]) ||
                   (writes_dest && eff_pending[f_dest]));

  assign instr_ready = !reset && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign stall       = instr_valid && !instr_ready;

  logic [7:0] rd_a, rd_b;

  assign rd_a = (wb_en && (wb_addr == f_src_a)) ? wb_data : rf_q[f_src_a];
  assign rd_b = (wb_en && (wb_addr == f_src_b)) ? wb_data : rf_q[f_src_b];

  always_comb begin
    set_mask = '0;
    if (accept && writes_dest) set_mask[f_dest] = 1'b1;
  end

  // Set is OR-ed after the clear so an issue to the written-back register keeps it pending.
  assign pending_d = (pending_q & ~wb_mask) | set_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      pending_q <= '0;
    end else begin
      if (wb_en) rf_q[wb_addr] <= wb_data;
      pending_q <= pending_d;
    end
  end

  logic [3:0]  opcode_q, opcode_d;
  logic [2:0]  dest_q, dest_d, a_adr_q, a_adr_d, b_adr_q, b_adr_d;
  logic [3:0]  sda_q, sda_d;
  logic [7:0]  opnd_a_q, opnd_a_d, opnd_b_q, opnd_b_d;
  logic        issue_valid_q, issue_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    opcode_d      = '0;
    dest_d        = '0;
    a_adr_d       = '0;
    b_adr_d       = '0;
    sda_d         = '0;
    opnd_a_d      = '0;
    opnd_b_d      = '0;
    issue_valid_d = 1'b0;
    if (accept) begin
      opcode_d      = f_op;
      dest_d        = f_dest;
      a_adr_d       = f_src_a;
      b_adr_d       = f_src_b;
      sda_d         = f_addr;
      opnd_a_d      = rd_a;
      opnd_b_d      = rd_b;
      issue_valid_d = !is_nop;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q      <= '0;
      dest_q        <= '0;
      a_adr_q       <= '0;
      b_adr_q       <= '0;
      sda_q         <= '0;
      opnd_a_q      <= '0;
      opnd_b_q      <= '0;
      issue_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      opcode_q      <= opcode_d;
      dest_q        <= dest_d;
      a_adr_q       <= a_adr_d;
      b_adr_q       <= b_adr_d;
      sda_q         <= sda_d;
      opnd_a_q      <= opnd_a_d;
      opnd_b_q      <= opnd_b_d;
      issue_valid_q <= issue_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign opcode       = opcode_q;
  assign dest_reg     = dest_q;
  assign opAAdr       = a_adr_q;
  assign opBAdr       = b_adr_q;
  assign storeDataAdr = sda_q;
  assign operandA     = opnd_a_q;
  assign operandB     = opnd_b_q;
  assign issue_valid  = issue_valid_q;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: stimulus pushes expected issues, a negedge monitor
// pops and compares whenever issue_valid is high.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [3:0]  opcode;
  logic [2:0]  dest_reg, opAAdr, opBAdr;
  logic [3:0]  storeDataAdr;
  logic [7:0]  operandA, operandB;
  logic        issue_valid;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] dst;
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] sda;
    logic [7:0] oa;
    logic [7:0] ob;
  } exp_t;

  exp_t exp_q [$];

  always #5 clk = ~clk;

  decode_issue dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .opcode       (opcode),
    .dest_reg     (dest_reg),
    .opAAdr       (opAAdr),
    .opBAdr       (opBAdr),
    .storeDataAdr (storeDataAdr),
    .operandA     (operandA),
    .operandB     (operandB),
    .issue_valid  (issue_valid),
    .stall_count  (stall_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] a,
                      input logic [2:0] b, input logic [3:0] sda, input logic [7:0] oa,
                      input logic [7:0] ob);
    exp_q.push_back('{op: op, dst: dst, a: a, b: b, sda: sda, oa: oa, ob: ob});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string name);
    check(name, {issue_valid, opcode, dest_reg, opAAdr, opBAdr, storeDataAdr, operandA,
                 operandB}, '0);
  endtask

  // Monitor: every issued instruction must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && issue_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_issue: got opcode %0h, required no issue", opcode);
      end else begin
        exp_t e;
        exp_t act;
        e   = exp_q.pop_front();
        act = '{op: opcode, dst: dest_reg, a: opAAdr, b: opBAdr, sda: storeDataAdr,
                oa: operandA, ob: operandB};
        check("issue", 64'(act), 64'(e));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;

    // Reset held for 3 cycles
    repeat (3) tick();
    check("reset_ready", 64'(instr_ready), 0);
    check_bubble("reset_outputs");
    check("reset_stall_count", 64'(stall_count), 0);
    reset = 1'b0;
    #1;
    check("post_reset_ready", 64'(instr_ready), 1);
    tick();
    check_bubble("post_reset_idle");

    // Writeback r3 = 5A, then ALU 0x12D8
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h5A;
    tick();
    wb_en = 1'b0;
    instr = 16'h12D8; instr_valid = 1'b1;
    #1;
    check("alu_ready", 64'(instr_ready), 1);
    push(4'h1, 3'd1, 3'd3, 3'd3, 4'h8, 8'h5A, 8'h5A);
    tick();

    // RAW on r1 for 4 cycles
    instr = 16'h2440;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("raw_stall_ready", 64'(instr_ready), 0);
      tick();
      check_bubble("raw_bubble");
    end
    check("raw_stall_count", 64'(stall_count), 4);
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h33;
    #1;
    check("raw_release_ready", 64'(instr_ready), 1);
    push(4'h2, 3'd2, 3'd1, 3'd0, 4'h0, 8'h33, 8'h00);
    tick();
    wb_en = 1'b0; instr_valid = 1'b0;

    // Writeback r2 = 77 (also clears r2 pending), then STORE 0xF089
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h77;
    tick();
    wb_en = 1'b0;
    instr = 16'hF089; instr_valid = 1'b1;
    #1;
    check("store_ready", 64'(instr_ready), 1);
    push(4'hF, 3'd0, 3'd2, 3'd1, 4'h9, 8'h77, 8'h33);
    tick();
    // Store must not mark r0 pending
    instr = 16'h3000;
    #1;
    check("store_no_pending", 64'(instr_ready), 1);
    push(4'h3, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00, 8'h00);
    tick();

    // LOAD r4 then WAW LOAD r4
    instr = 16'hE806;
    #1;
    check("load1_ready", 64'(instr_ready), 1);
    push(4'hE, 3'd4, 3'd0, 3'd0, 4'h6, 8'h00, 8'h00);
    tick();
    instr = 16'hE807;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("waw_stall_ready", 64'(instr_ready), 0);
      tick();
    end
    check("waw_stall_count", 64'(stall_count), 6);
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h11;
    #1;
    check("waw_release_ready", 64'(instr_ready), 1);
    push(4'hE, 3'd4, 3'd0, 3'd0, 4'h7, 8'h00, 8'h00);
    tick();
    wb_en = 1'b0;

    // LOAD r1, then RAW stall interrupted by reset
    instr = 16'hE200;
    push(4'hE, 3'd1, 3'd0, 3'd0, 4'h0, 8'h00, 8'h00);
    tick();
    instr = 16'h2440;
    #1;
    check("reset_raw_stall", 64'(instr_ready), 0);
    tick();
    check("reset_raw_count", 64'(stall_count), 7);
    reset = 1'b1;
    #1;
    check("midstall_reset_ready", 64'(instr_ready), 0);
    check_bubble("midstall_reset_outputs");
    check("midstall_reset_count", 64'(stall_count), 0);
    tick();
    reset = 1'b0;
    #1;
    check("after_reset_ready", 64'(instr_ready), 1);
    push(4'h2, 3'd2, 3'd1, 3'd0, 4'h0, 8'h00, 8'h00);
    tick();
    instr_valid = 1'b0;
    repeat (2) tick();
    check_bubble("final_idle");
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/operand-fetch stage directly upstream of the execute unit. Accepts 16-bit instructions from fetch with a valid/ready handshake and decodes the fields. Reads operands from an internal 8x8 register file that the writeback stage writes. A per-register scoreboard interlocks RAW and WAW hazards by stalling fetch and issuing NOP bubbles. All outputs to the execute unit are registered.

## Interface
- No parameters. Widths are fixed: 8 registers x 8 bits, 16-entry data-memory address space, 4-bit opcode.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- instr  in  16  instruction word from fetch
- instr_valid  in  1  instr holds a valid instruction
- instr_ready  out  1  decode accepts instr this cycle (combinational)
- wb_en  in  1  register-file write enable from writeback
- wb_addr  in  3  writeback destination register
- wb_data  in  8  writeback data
- opcode  out  4  issued opcode; 0000 = NOP/bubble
- dest_reg  out  3  issued destination register
- opAAdr  out  3  issued source A register index
- opBAdr  out  3  issued source B register index
- storeDataAdr  out  4  issued data-memory address (load/store)
- operandA  out  8  value of source A
- operandB  out  8  value of source B
- issue_valid  out  1  outputs carry a real, non-bubble instruction
- stall_count  out  16  saturating count of stall cycles

## Operation
- Instruction fields:
  - opcode = instr[15:12]
  - dest = instr[11:9]
  - srcA = instr[8:6]
  - srcB = instr[5:3]
  - addr = instr[3:0]
- Instruction classes:
  - 0000 NOP: reads nothing, writes nothing.
  - 1110 LOAD: writes dest, reads nothing.
  - 1111 STORE: reads srcA, writes no register.
  - All other opcodes are ALU: read srcA and srcB, write dest.
- Register file:
  - 8x8, all entries 0 on reset.
  - Written at posedge when wb_en = 1.
  - Reads are combinational with write-first bypass: if wb_en and wb_addr equals the read index, the read returns wb_data.
- Scoreboard:
  - pending[7:0], cleared to 0 on reset.
  - On issue of a LOAD or ALU instruction, pending[dest] is set.
  - On wb_en, pending[wb_addr] is cleared.
  - If set and clear target the same register in the same cycle, set wins.
- Effective pending: eff[r] = pending[r] && !(wb_en && wb_addr == r).
- Hazard: instr_valid, and the instruction reads any register r with eff[r], or writes dest with eff[dest] (WAW).
- Handshake:
  - instr_ready = !reset && !hazard.
  - An instruction is accepted when instr_valid && instr_ready.
  - Fetch must hold instr stable while instr_valid && !instr_ready.
- On accept, at the next edge:
  - opcode, dest_reg, opAAdr, opBAdr and storeDataAdr take the decoded fields.
  - operandA and operandB take the bypassed register reads.
  - issue_valid = (opcode != 0000).
- On no accept (no valid instruction, or stall), at the next edge:
  - Outputs become a bubble: opcode = 0000, issue_valid = 0, all other outputs 0.
- stall_count increments on every cycle with instr_valid && !instr_ready, and saturates at 0xFFFF.
- Reset values: every registered output is 0; instr_ready = 0 while reset is asserted.
- Reset asserted mid-stall clears pending, the register file and the outputs. The stalled instruction is not issued, and fetch re-presents it.

## Timing
- Accept in cycle N: the instruction appears on the outputs in cycle N+1. The execute unit registers it at the end of N+1.
- A dependent instruction stalls until the cycle in which wb_en writes the pending register. It is accepted in that same cycle and uses the bypassed wb_data. It issues in the following cycle.
- Back-to-back independent instructions issue one per cycle with no bubbles.
- instr_ready is combinational from instr, instr_valid, pending, wb_en and wb_addr. It has no path from any output register.
- wb_en to a register that is not pending only updates the register file; the scoreboard is unaffected.

## Test plan
- Reset: hold reset for 3 cycles. Required: all outputs 0 and instr_ready = 0. After release with instr_valid = 0: instr_ready = 1, opcode = 0, issue_valid = 0.
- Writeback r3 = 0x5A, then issue 0x12D8 (ALU 0001, dest r1, srcA r3, srcB r3). Required next cycle: opcode 1, dest_reg 1, operandA = operandB = 0x5A, issue_valid = 1. pending[1] is set.
- After the previous case, present 0x2440 (reads r1) for 4 cycles with no writeback. Required: instr_ready = 0 and 4 bubbles; stall_count = 4. Then wb_en r1 = 0x33: accepted that cycle; next cycle operandA = 0x33.
- Writeback r2 = 0x77, then issue 0xF089 (STORE, srcA r2, addr 9). Required: opcode F, operandA 0x77, storeDataAdr 9. pending is unchanged.
- Issue 0xE806 (LOAD r4, addr 6), then 0xE807 (LOAD r4). Required: the second load stalls (WAW). On wb_en r4 it is accepted and issues with storeDataAdr 7.
- Assert reset during the stall in the RAW case. Required: pending cleared, outputs 0, stall_count 0. After release, the held instruction is accepted immediately and operandA = 0.
